// File: rtl/fibo_pkg.sv
// Shared constants and state type for the Fibonacci calculator / index finder pair.
package fibo_pkg;
    localparam int FIBO_W       = 16;
    localparam int IDX_W        = 5;
    localparam int FIBO_MAX_IDX = 24;
    // One extra bit so F(25)=75025 fits while searching past 16-bit targets.
    localparam int PAIR_W       = FIBO_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } fibo_idx_state_t;
endpackage

// File: rtl/fibo_pair_gen.sv
// Holds the running Fibonacci pair (R0 = F(idx), R1 = F(idx-1)); load seeds F(1), step advances.
module fibo_pair_gen
    import fibo_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    output logic [PAIR_W-1:0] r0
);
    logic [PAIR_W-1:0] r0_q, r0_d;
    logic [PAIR_W-1:0] r1_q, r1_d;

    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        if (load) begin
            r0_d = PAIR_W'(1);
            r1_d = '0;
        end else if (step) begin
            r0_d = r0_q + r1_q;
            r1_d = r0_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_q <= '0;
            r1_q <= '0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
        end
    end

    assign r0 = r0_q;
endmodule

// File: rtl/fibonacci_index_finder.sv
// Classifies a 16-bit value as Fibonacci (exact index) or returns the floor index.
// Optional FIBO_INDEX_TRACE_EN prints per-cycle search state in simulation.
module fibonacci_index_finder
    import fibo_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FIBO_W-1:0] fibo_in,
    input  logic              begin_index,
    output logic [IDX_W-1:0]  index_out,
    output logic              is_fibo,
    output logic              done
);
    fibo_idx_state_t   state_q, state_d;
    logic [FIBO_W-1:0] target_q, target_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  index_out_q, index_out_d;
    logic              is_fibo_q, is_fibo_d;
    logic              pair_load, pair_step;
    logic [PAIR_W-1:0] r0;
    logic [PAIR_W-1:0] target_ext;

    assign target_ext = {1'b0, target_q};

    // Zero also goes through SEARCH: F(1)=1 > 0 floors to index 0 one edge later,
    // giving the same single-edge latency as value 1.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        idx_d       = idx_q;
        index_out_d = index_out_q;
        is_fibo_d   = is_fibo_q;
        pair_load   = 1'b0;
        pair_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (begin_index) begin
                    target_d    = fibo_in;
                    idx_d       = IDX_W'(1);
                    index_out_d = '0;
                    is_fibo_d   = 1'b0;
                    pair_load   = 1'b1;
                    state_d     = SEARCH;
                end
            end
            SEARCH: begin
                if (r0 == target_ext) begin
                    index_out_d = idx_q;
                    is_fibo_d   = 1'b1;
                    state_d     = DONE;
                end else if (r0 > target_ext) begin
                    index_out_d = idx_q - IDX_W'(1);
                    is_fibo_d   = 1'b0;
                    state_d     = DONE;
                end else begin
                    pair_step = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            idx_q       <= '0;
            index_out_q <= '0;
            is_fibo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            idx_q       <= idx_d;
            index_out_q <= index_out_d;
            is_fibo_q   <= is_fibo_d;
        end
    end

    fibo_pair_gen u_pair (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pair_load),
        .step    (pair_step),
        .r0      (r0)
    );

    assign index_out = index_out_q;
    assign is_fibo   = is_fibo_q;
    assign done      = (state_q == DONE);

`ifdef FIBO_INDEX_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset_n && state_q == SEARCH)
            $display("fibo_idx: state=%s idx=%0d R0=%0d R1=%0d target=%0d",
                     state_q.name(), idx_q, r0, u_pair.r1_q, target_q);
        if (reset_n && state_q == DONE)
            $display("fibo_idx: result index_out=%0d is_fibo=%0b", index_out_q, is_fibo_q);
    end
`else
`endif
endmodule
